// File: rtl/sram_ring_ctrl.sv
// Ring-buffer FIFO controller over an external asynchronous 16-bit SRAM.
// One strobed SRAM cycle at a time; every access returns through IDLE.
module sram_ring_ctrl #(
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic                  CLEAR,
  input  logic [15:0]           IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [15:0]           OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [ADDR_WIDTH:0]   SIZE,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  inout  wire  [15:0]           SRAM_IO,
  output logic                  SRAM_BHE_B,
  output logic                  SRAM_BLE_B,
  output logic                  SRAM_CE1_B,
  output logic                  SRAM_OE_B,
  output logic                  SRAM_WE_B
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_SETUP,
    RD_WAIT,
    RD_CAPT
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  logic clr;

  state_e state_q, state_d;
  op_e    last_op_q, last_op_d;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   size_q, size_d;

  logic        hold_valid_q, hold_valid_d;
  logic [15:0] hold_data_q, hold_data_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;

  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [15:0] io_out_q, io_out_d;
  logic        io_oe_q, io_oe_d;
  logic        ce_b_q, ce_b_d;
  logic        oe_b_q, oe_b_d;
  logic        we_b_q, we_b_d;

  logic empty, full;
  logic in_fire, out_fire;
  logic wr_req, rd_req;

  assign clr   = BUS_RST | CLEAR;
  assign empty = (size_q == '0);
  assign full  = (size_q == DEPTH_W);

  assign IN_READY = !hold_valid_q && !clr;
  assign in_fire  = IN_VALID && IN_READY;
  assign out_fire = out_valid_q && OUT_READY;

  assign wr_req = hold_valid_q && !full;
  assign rd_req = !out_valid_q && !empty;

  always_comb begin
    state_d      = state_q;
    last_op_d    = last_op_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    size_d       = size_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    if (in_fire) begin
      hold_valid_d = 1'b1;
      hold_data_d  = IN_DATA;
    end
    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // On contention alternate so neither stream starves.
        if (wr_req && (!rd_req || last_op_q == OP_READ)) begin
          state_d = WR_SETUP;
        end else if (rd_req) begin
          state_d = RD_SETUP;
        end
      end
      WR_SETUP:  state_d = WR_STROBE;
      WR_STROBE: state_d = WR_HOLD;
      WR_HOLD: begin
        state_d      = IDLE;
        wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(1);
        size_d       = size_q + (ADDR_WIDTH+1)'(1);
        hold_valid_d = 1'b0;
        last_op_d    = OP_WRITE;
      end
      RD_SETUP: state_d = RD_WAIT;
      RD_WAIT:  state_d = RD_CAPT;
      RD_CAPT: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_data_d  = SRAM_IO;
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
        size_d      = size_q - (ADDR_WIDTH+1)'(1);
        last_op_d   = OP_READ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin levels follow the state being entered so they come from flops.
  always_comb begin
    a_d      = a_q;
    io_out_d = io_out_q;
    io_oe_d  = 1'b0;
    ce_b_d   = 1'b1;
    oe_b_d   = 1'b1;
    we_b_d   = 1'b1;

    unique case (state_d)
      WR_SETUP: begin
        ce_b_d   = 1'b0;
        io_oe_d  = 1'b1;
        a_d      = wr_ptr_q;
        io_out_d = hold_data_q;
      end
      WR_STROBE: begin
        ce_b_d  = 1'b0;
        io_oe_d = 1'b1;
        we_b_d  = 1'b0;
      end
      WR_HOLD: begin
        ce_b_d  = 1'b0;
        io_oe_d = 1'b1;
      end
      RD_SETUP: begin
        ce_b_d = 1'b0;
        oe_b_d = 1'b0;
        a_d    = rd_ptr_q;
      end
      RD_WAIT, RD_CAPT: begin
        ce_b_d = 1'b0;
        oe_b_d = 1'b0;
      end
      default: begin
        ce_b_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (clr) begin
      state_q      <= IDLE;
      last_op_q    <= OP_READ;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      size_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      a_q          <= '0;
      io_out_q     <= '0;
      io_oe_q      <= 1'b0;
      ce_b_q       <= 1'b1;
      oe_b_q       <= 1'b1;
      we_b_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_op_q    <= last_op_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      size_q       <= size_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      a_q          <= a_d;
      io_out_q     <= io_out_d;
      io_oe_q      <= io_oe_d;
      ce_b_q       <= ce_b_d;
      oe_b_q       <= oe_b_d;
      we_b_q       <= we_b_d;
    end
  end

  assign SRAM_IO    = io_oe_q ? io_out_q : {16{1'bz}};
  assign SRAM_A     = a_q;
  assign SRAM_CE1_B = ce_b_q;
  assign SRAM_BHE_B = ce_b_q;
  assign SRAM_BLE_B = ce_b_q;
  assign SRAM_OE_B  = oe_b_q;
  assign SRAM_WE_B  = we_b_q;

  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign SIZE      = size_q;
  assign EMPTY     = empty;
  assign FULL      = full;

endmodule

// File: tb/tb_sram_ring_ctrl.sv
// Bench for sram_ring_ctrl with a small SRAM model and a queue-based
// reference FIFO (16-word ring so wrap and full are reachable).
module tb_sram_ring_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic          in_ready;
  logic [15:0]   out_data;
  logic          out_valid;
  logic [AW:0]   size;
  logic          empty, full;
  logic [AW-1:0] sram_a;
  wire  [15:0]   sram_io;
  logic bhe_b, ble_b, ce_b, oe_b, we_b;

  sram_ring_ctrl #(.ADDR_WIDTH(AW)) dut (
    .BUS_CLK   (clk),
    .BUS_RST   (rst),
    .CLEAR     (clear),
    .IN_DATA   (in_data),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .OUT_DATA  (out_data),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .SIZE      (size),
    .EMPTY     (empty),
    .FULL      (full),
    .SRAM_A    (sram_a),
    .SRAM_IO   (sram_io),
    .SRAM_BHE_B(bhe_b),
    .SRAM_BLE_B(ble_b),
    .SRAM_CE1_B(ce_b),
    .SRAM_OE_B (oe_b),
    .SRAM_WE_B (we_b)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:DEPTH-1];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always @(negedge we_b) begin
    if (!ce_b) mem[sram_a] = sram_io;
  end

  assign sram_io = (!oe_b && !ce_b) ? mem[sram_a] : {16{1'bz}};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] model_q [$];
  int n_out = 0;

  // Reference: every accepted word leaves in order; a word accepted but
  // not yet delivered is in the holding reg, the SRAM, or the output reg.
  always @(negedge clk) begin
    if (rst || clear) begin
      model_q.delete();
    end else begin
      int exp_sz;
      exp_sz = model_q.size() - (in_ready ? 0 : 1) - (out_valid ? 1 : 0);
      check("size_track", 32'(size), exp_sz);
      check("size_max", 32'(size <= DEPTH), 1);
      check("empty_flag", 32'(empty), 32'(size == 0));
      check("full_flag", 32'(full), 32'(size == DEPTH));
      if (!oe_b) check("oe_bus_clean", 32'($isunknown(sram_io)), 0);
      if (!we_b) check("we_vs_oe", 32'(oe_b), 1);
      if (out_valid && out_ready) begin
        check("out_avail", 32'(model_q.size() > 0), 1);
        if (model_q.size() > 0) check("out_data", 32'(out_data), 32'(model_q.pop_front()));
        n_out++;
      end
      if (in_valid && in_ready) model_q.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int done = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (model_q.size() == 0 && !out_valid && in_ready) begin
        done = 1;
        break;
      end
      tick();
    end
    check("drain_done", done, 1);
  endtask

  // mode 0: out_ready untouched, 1: toggle, 2: random valid/ready
  task automatic send(input int n, input int seq, input logic [15:0] base,
                      input int mode, input int budget);
    int sent = 0;
    int cyc  = 0;
    logic acc;
    while (sent < n && cyc < budget) begin
      in_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = seq ? base + 16'(sent) : 16'($urandom);
      if (mode == 1) out_ready = ~out_ready;
      if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    check("send_count", sent, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_cnt, acc_cnt, oe_cnt, found, out0;
    logic acc;

    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_io_z", 32'(sram_io === 16'hzzzz), 1);
    check("rst_ctrl", {27'd0, we_b, oe_b, ce_b, bhe_b, ble_b}, 32'h1f);
    check("rst_addr", 32'(sram_a), 0);
    check("rst_size", 32'(size), 0);
    check("rst_flags", {30'd0, empty, full}, 32'h2);
    check("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // single word latency and pin timing
    in_data  = 16'hA5C3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    we_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (!we_b) we_cnt++;
      if (k >= 1 && k <= 3) begin
        check($sformatf("wr_addr_k%0d", k), 32'(sram_a), 0);
        check($sformatf("wr_io_k%0d", k), 32'(sram_io), 32'hA5C3);
        check($sformatf("wr_ce_k%0d", k), 32'(ce_b), 0);
      end
      if (k == 2) check("wr_strobe", 32'(we_b), 0);
      if (k == 4) begin
        check("idle_io_z", 32'(sram_io === 16'hzzzz), 1);
        check("size_after_wr", 32'(size), 1);
      end
      if (k >= 5 && k <= 7) check($sformatf("rd_oe_k%0d", k), 32'(oe_b), 0);
      if (k == 7) check("no_early_valid", 32'(out_valid), 0);
      if (k == 8) begin
        check("lat_valid", 32'(out_valid), 1);
        check("lat_data", 32'(out_data), 32'hA5C3);
        check("lat_size", 32'(size), 0);
        check("lat_oe_off", 32'(oe_b), 1);
      end
    end
    check("we_pulse_len", we_cnt, 1);
    drain(100);

    // 100 sequential words streamed straight through
    out0 = n_out;
    out_ready = 1'b1;
    send(100, 1, 16'd0, 0, 3000);
    drain(500);
    check("seq100_count", n_out - out0, 100);

    // fill: 1 in output reg + 16 in SRAM + 1 held
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      in_valid = (acc_cnt < 20);
      in_data  = 16'h300 + 16'(acc_cnt);
      acc = in_valid && in_ready;
      tick();
      if (acc) acc_cnt++;
    end
    in_valid = 1'b0;
    check("fill_accepted", acc_cnt, 18);
    check("fill_full", 32'(full), 1);
    check("fill_size", 32'(size), DEPTH);
    check("fill_in_ready", 32'(in_ready), 0);
    check("fill_out_valid", 32'(out_valid), 1);
    out0 = n_out;
    drain(1000);
    check("fill_drained", n_out - out0, 18);

    // wrap twice with toggling consumer
    out0 = n_out;
    send(40, 1, 16'h100, 1, 3000);
    drain(1000);
    check("wrap_count", n_out - out0, 40);

    // random traffic
    send(80, 0, 16'd0, 2, 6000);
    drain(1000);

    // reset during write strobe
    out_ready = 1'b0;
    in_data   = 16'($urandom);
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (!we_b) begin
        found = 1;
        break;
      end
      tick();
    end
    check("saw_strobe", found, 1);
    rst = 1'b1;
    tick();
    check("rst_we_off", 32'(we_b), 1);
    check("rst_mid_size", 32'(size), 0);
    check("rst_mid_empty", 32'(empty), 1);
    check("rst_mid_valid", 32'(out_valid), 0);
    check("rst_mid_io_z", 32'(sram_io === 16'hzzzz), 1);
    rst = 1'b0;
    repeat (4) tick();
    check("rst_abort_valid", 32'(out_valid), 0);
    check("rst_abort_size", 32'(size), 0);

    // clear during read wait with 5 words stored
    out_ready = 1'b0;
    send(6, 1, 16'h200, 0, 200);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (size == 5 && in_ready) begin
        found = 1;
        break;
      end
      tick();
    end
    check("clr_setup", found, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    oe_cnt = 0;
    found  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!oe_b) oe_cnt++;
      if (oe_cnt == 2) begin
        found = 1;
        break;
      end
    end
    check("saw_rd_wait", found, 1);
    check("clr_size_before", 32'(size), 5);
    clear = 1'b1;
    tick();
    check("clr_oe_off", 32'(oe_b), 1);
    check("clr_size", 32'(size), 0);
    check("clr_valid", 32'(out_valid), 0);
    clear = 1'b0;
    repeat (3) tick();
    check("clr_valid_stays", 32'(out_valid), 0);
    in_data  = 16'h0BEE;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (!we_b) begin
        found = 1;
        break;
      end
      tick();
    end
    check("clr_saw_write", found, 1);
    check("clr_write_addr", 32'(sram_a), 0);
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
